mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the single-issue MIPS-subset core.
- Consumes opcode/funcode from the instruction field decoder, ALU zero flag and memory ready strobes.
- Sequences fetch, decode, execute, memory and writeback by driving the datapath enables and muxes cycle by cycle.
- Also flags illegal instructions and counts retired instructions.

Parameters:
- ILLEGAL_HALT, 1, 1: illegal opcode/funct parks in TRAP until reset; 0: treated as NOP, returns to FETCH.
- RETIRE_CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  instr[31:26], valid from DECODE onward (IR held).
- funcode  in  6  instr[5:0].
- alu_zero  in  1  ALU result == 0.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data read valid / write accepted this cycle.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  load instruction register.
- pc_we  out  1  PC write enable.
- pc_src  out  2  0=PC+4, 1=branch target, 2=jump target.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data access is a write.
- rf_we  out  1  register file write enable.
- rf_dst_sel  out  1  0=rt, 1=rd.
- rf_wdata_sel  out  1  0=ALU result, 1=memory data.
- alu_src_b  out  1  0=rt data, 1=extended immediate.
- ext_sel  out  1  0=zero-extend, 1=sign-extend.
- alu_op  out  3  0=ADD, 1=SUB, 2=AND, 3=OR, 4=SLT, 5=LUI.
- illegal  out  1  high while in TRAP.
- retire  out  1  one-cycle pulse on instruction completion.
- retire_cnt  out  RETIRE_CNT_W  retired instruction count, wraps.
- state_dbg  out  4  current state encoding.

Behaviour:
- Supported ops:
  - R-type (op 0x00): funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT.
  - I-type: ADDI 0x08 (sign-ext), ORI 0x0D (zero-ext), LUI 0x0F.
  - Memory: LW 0x23, SW 0x2B (sign-ext, ADD).
  - Control flow: BEQ 0x04 (SUB), J 0x02.
  - Anything else is illegal.
- States and encodings: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEM_ADDR 4, MEM_RD 5, MEM_WR 6, WB_R 7, WB_I 8, WB_MEM 9, BRANCH 10, JUMP 11, TRAP 12.
- Outputs: Moore from state, except strobes qualified by ready/zero as noted. Every output is 0 unless listed for the current state.
- FETCH:
  - imem_req=1 every cycle until imem_ready.
  - On the ready cycle: ir_we=1, pc_we=1, pc_src=0, next DECODE. Otherwise stay.
- DECODE:
  - R-type with legal funct -> EXEC_R.
  - ADDI/ORI/LUI -> EXEC_I.
  - LW/SW -> MEM_ADDR.
  - BEQ -> BRANCH.
  - J -> JUMP.
  - Otherwise -> TRAP if ILLEGAL_HALT=1; else retire=1 and -> FETCH.
- EXEC_R: alu_src_b=0, alu_op per funct -> WB_R.
- WB_R: same ALU controls held, rf_dst_sel=1, rf_we=1, retire=1 -> FETCH.
- EXEC_I: alu_src_b=1, ext_sel/alu_op per opcode -> WB_I.
- WB_I: same controls held, rf_dst_sel=0, rf_we=1, retire=1 -> FETCH.
- MEM_ADDR: alu_src_b=1, ext_sel=1, alu_op=ADD -> MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: address controls held, dmem_req=1, dmem_we=0. Stay until dmem_ready, then -> WB_MEM.
- WB_MEM: rf_wdata_sel=1, rf_dst_sel=0, rf_we=1, retire=1 -> FETCH.
- MEM_WR: address controls held, dmem_req=1, dmem_we=1. On dmem_ready: retire=1 -> FETCH.
- BRANCH: alu_src_b=0, alu_op=SUB, pc_src=1, pc_we=alu_zero, retire=1 -> FETCH.
- JUMP: pc_src=2, pc_we=1, retire=1 -> FETCH.
- TRAP: illegal=1, no enables asserted, held until rst.
- Latency with zero-wait memory (FETCH = 1 cycle), in cycles:
  - R/I-type: 4.
  - LW: 5.
  - SW: 4.
  - BEQ and J: 3.
  - Each memory wait cycle adds 1.
- retire_cnt increments by 1 on every retire cycle and wraps at 2^RETIRE_CNT_W to 0.
- Reset, including mid-operation:
  - rst sampled high -> state FETCH, retire_cnt=0.
  - Next cycle imem_req=1. An outstanding imem/dmem request is dropped immediately with no enables.
  - During the reset cycle all outputs except state_dbg (=0) are 0.
- ready asserted outside its request state is ignored.
- Simultaneous imem_ready and rst: rst wins, no ir_we.

Test Plan:
- Reset then ADD (op 0, funct 0x20), imem_ready tied 1 -> states 0,1,2,7. WB_R: rf_we=1, rf_dst_sel=1, alu_op=0. retire_cnt=1 after 4 cycles.
- LW (0x23) with dmem_ready low 3 cycles -> MEM_RD held with dmem_req=1, dmem_we=0 for 4 cycles. Then WB_MEM: rf_wdata_sel=1. Total 8 cycles.
- BEQ with alu_zero=1, then alu_zero=0 -> BRANCH: pc_src=1, pc_we=1 then 0. Both retire, each in 3 cycles.
- J then SW with dmem_ready=1 -> JUMP: pc_we=1, pc_src=2. MEM_WR: dmem_req=1, dmem_we=1. retire_cnt +2.
- opcode 0x3F, ILLEGAL_HALT=1 -> TRAP, illegal=1, stuck 10 cycles, no enables. rst -> FETCH, retire_cnt=0.
- rst asserted in MEM_RD while dmem_req=1 -> next state FETCH, dmem_req=0, rf_we never asserted.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle sequencer (master) and the datapath/memories (slave).
interface mc_ctrl_if #(
    parameter int unsigned RETIRE_CNT_W = 32
);
    logic [5:0]              opcode;
    logic [5:0]              funcode;
    logic                    alu_zero;
    logic                    imem_ready;
    logic                    dmem_ready;
    logic                    imem_req;
    logic                    ir_we;
    logic                    pc_we;
    logic [1:0]              pc_src;
    logic                    dmem_req;
    logic                    dmem_we;
    logic                    rf_we;
    logic                    rf_dst_sel;
    logic                    rf_wdata_sel;
    logic                    alu_src_b;
    logic                    ext_sel;
    logic [2:0]              alu_op;
    logic                    illegal;
    logic                    retire;
    logic [RETIRE_CNT_W-1:0] retire_cnt;
    logic [3:0]              state_dbg;

    modport master (
        input  opcode, funcode, alu_zero, imem_ready, dmem_ready,
        output imem_req, ir_we, pc_we, pc_src, dmem_req, dmem_we,
               rf_we, rf_dst_sel, rf_wdata_sel, alu_src_b, ext_sel, alu_op,
               illegal, retire, retire_cnt, state_dbg
    );

    modport slave (
        output opcode, funcode, alu_zero, imem_ready, dmem_ready,
        input  imem_req, ir_we, pc_we, pc_src, dmem_req, dmem_we,
               rf_we, rf_dst_sel, rf_wdata_sel, alu_src_b, ext_sel, alu_op,
               illegal, retire, retire_cnt, state_dbg
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer for the MIPS-subset core: fetch/decode/execute/mem/writeback,
// illegal-instruction trap and retired-instruction counter.
module mc_ctrl_fsm #(
    parameter bit          ILLEGAL_HALT = 1'b1,
    parameter int unsigned RETIRE_CNT_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_R     = 4'd7,
        WB_I     = 4'd8,
        WB_MEM   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        TRAP     = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_LUI = 3'd5
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    state_t                  state;
    state_t                  dec_next;
    logic                    dec_illegal;
    logic [RETIRE_CNT_W-1:0] cnt;

    logic    r_legal;
    alu_op_t r_op;
    alu_op_t i_op;
    logic    i_ext;

    logic    imem_req, ir_we, pc_we, dmem_req, dmem_we;
    logic    rf_we, rf_dst_sel, rf_wdata_sel, alu_src_b, ext_sel;
    logic    illegal, retire;
    logic [1:0] pc_src;
    alu_op_t aop;

    always_comb begin
        r_legal = 1'b1;
        r_op    = ALU_ADD;
        case (bus.funcode)
            FN_ADD:  r_op = ALU_ADD;
            FN_SUB:  r_op = ALU_SUB;
            FN_AND:  r_op = ALU_AND;
            FN_OR:   r_op = ALU_OR;
            FN_SLT:  r_op = ALU_SLT;
            default: r_legal = 1'b0;
        endcase
    end

    always_comb begin
        i_op  = ALU_ADD;
        i_ext = 1'b0;
        case (bus.opcode)
            OP_ADDI: begin
                i_op  = ALU_ADD;
                i_ext = 1'b1;
            end
            OP_ORI:  i_op = ALU_OR;
            OP_LUI:  i_op = ALU_LUI;
            default: ;
        endcase
    end

    always_comb begin
        dec_next    = ILLEGAL_HALT ? TRAP : FETCH;
        dec_illegal = 1'b1;
        case (bus.opcode)
            OP_RTYPE: begin
                if (r_legal) begin
                    dec_next    = EXEC_R;
                    dec_illegal = 1'b0;
                end
            end
            OP_ADDI, OP_ORI, OP_LUI: begin
                dec_next    = EXEC_I;
                dec_illegal = 1'b0;
            end
            OP_LW, OP_SW: begin
                dec_next    = MEM_ADDR;
                dec_illegal = 1'b0;
            end
            OP_BEQ: begin
                dec_next    = BRANCH;
                dec_illegal = 1'b0;
            end
            OP_J: begin
                dec_next    = JUMP;
                dec_illegal = 1'b0;
            end
            default: ;
        endcase
    end

    // Outputs decode from state but are forced low while rst is sampled, so a
    // coincident ready strobe never produces an enable.
    always_comb begin
        imem_req     = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'd0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        rf_we        = 1'b0;
        rf_dst_sel   = 1'b0;
        rf_wdata_sel = 1'b0;
        alu_src_b    = 1'b0;
        ext_sel      = 1'b0;
        aop          = ALU_ADD;
        illegal      = 1'b0;
        retire       = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = bus.imem_ready;
                    pc_we    = bus.imem_ready;
                end
                DECODE: retire = dec_illegal && !ILLEGAL_HALT;
                EXEC_R: aop = r_op;
                WB_R: begin
                    aop        = r_op;
                    rf_dst_sel = 1'b1;
                    rf_we      = 1'b1;
                    retire     = 1'b1;
                end
                EXEC_I: begin
                    alu_src_b = 1'b1;
                    ext_sel   = i_ext;
                    aop       = i_op;
                end
                WB_I: begin
                    alu_src_b = 1'b1;
                    ext_sel   = i_ext;
                    aop       = i_op;
                    rf_we     = 1'b1;
                    retire    = 1'b1;
                end
                MEM_ADDR: begin
                    alu_src_b = 1'b1;
                    ext_sel   = 1'b1;
                end
                MEM_RD: begin
                    alu_src_b = 1'b1;
                    ext_sel   = 1'b1;
                    dmem_req  = 1'b1;
                end
                MEM_WR: begin
                    alu_src_b = 1'b1;
                    ext_sel   = 1'b1;
                    dmem_req  = 1'b1;
                    dmem_we   = 1'b1;
                    retire    = bus.dmem_ready;
                end
                WB_MEM: begin
                    rf_wdata_sel = 1'b1;
                    rf_we        = 1'b1;
                    retire       = 1'b1;
                end
                BRANCH: begin
                    aop    = ALU_SUB;
                    pc_src = 2'd1;
                    pc_we  = bus.alu_zero;
                    retire = 1'b1;
                end
                JUMP: begin
                    pc_src = 2'd2;
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end
                TRAP:    illegal = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            cnt   <= '0;
        end else begin
            if (retire) begin
                cnt <= cnt + RETIRE_CNT_W'(1);
            end
            case (state)
                FETCH:    if (bus.imem_ready) state <= DECODE;
                DECODE:   state <= dec_next;
                EXEC_R:   state <= WB_R;
                EXEC_I:   state <= WB_I;
                MEM_ADDR: state <= (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
                MEM_RD:   if (bus.dmem_ready) state <= WB_MEM;
                MEM_WR:   if (bus.dmem_ready) state <= FETCH;
                WB_R, WB_I, WB_MEM, BRANCH, JUMP: state <= FETCH;
                TRAP:     state <= TRAP;
                default:  state <= FETCH;
            endcase
        end
    end

    assign bus.imem_req     = imem_req;
    assign bus.ir_we        = ir_we;
    assign bus.pc_we        = pc_we;
    assign bus.pc_src       = pc_src;
    assign bus.dmem_req     = dmem_req;
    assign bus.dmem_we      = dmem_we;
    assign bus.rf_we        = rf_we;
    assign bus.rf_dst_sel   = rf_dst_sel;
    assign bus.rf_wdata_sel = rf_wdata_sel;
    assign bus.alu_src_b    = alu_src_b;
    assign bus.ext_sel      = ext_sel;
    assign bus.alu_op       = aop;
    assign bus.illegal      = illegal;
    assign bus.retire       = retire;
    assign bus.retire_cnt   = rst ? '0 : cnt;
    assign bus.state_dbg    = rst ? 4'd0 : state;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: a per-instruction cycle-table model expands each
// instruction into its expected per-cycle outputs, and a negedge process compares.
module tb_mc_ctrl_fsm;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic [3:0] st;
        logic       ireq;
        logic       irwe;
        logic       pcwe;
        logic [1:0] pcs;
        logic       dreq;
        logic       dwe;
        logic       rfwe;
        logic       dst;
        logic       wsel;
        logic       srcb;
        logic       ext;
        logic [2:0] aop;
        logic       ill;
        logic       ret;
    } ov_t;

    typedef struct {
        logic          rst;
        logic          imr;
        logic          dmr;
        logic          z;
        logic [5:0]    op;
        logic [5:0]    fn;
        ov_t           o;
        logic [CW-1:0] cnt;
        string         tag;
    } rec_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    rec_t plan[$];
    rec_t chk[$];
    logic [CW-1:0] mcnt;

    mc_ctrl_if #(.RETIRE_CNT_W(CW)) bus ();

    mc_ctrl_fsm #(
        .ILLEGAL_HALT (1'b1),
        .RETIRE_CNT_W (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic r, input logic imr, input logic dmr, input logic z,
                        input logic [5:0] op, input logic [5:0] fn, input ov_t o, input string tag);
        rec_t e;
        e.rst = r; e.imr = imr; e.dmr = dmr; e.z = z;
        e.op = op; e.fn = fn; e.o = o; e.tag = tag;
        e.cnt = r ? '0 : mcnt;
        plan.push_back(e);
        if (r) mcnt = '0;
        else if (o.ret) mcnt = mcnt + 1'b1;
    endtask

    task automatic reset_cycle(input string tag);
        ov_t o;
        o = '0;
        step(1'b1, 1'b1, 1'b1, 1'b0, 6'h00, 6'h20, o, tag);
    endtask

    // Expand one instruction into its cycle table; iw/dw are memory wait cycles,
    // bg is the value both ready lines carry outside their own request cycles.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input int iw, input int dw,
                         input logic z, input logic bg, input string tag);
        ov_t o;
        logic [2:0] a;
        for (int i = 0; i < iw; i++) begin
            o = '0; o.ireq = 1'b1;
            step(1'b0, 1'b0, bg, z, op, fn, o, tag);
        end
        o = '0; o.ireq = 1'b1; o.irwe = 1'b1; o.pcwe = 1'b1;
        step(1'b0, 1'b1, bg, z, op, fn, o, tag);
        o = '0; o.st = 4'd1;
        step(1'b0, bg, bg, z, op, fn, o, tag);
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)) begin
            a = (fn == 6'h20) ? 3'd0 : (fn == 6'h22) ? 3'd1 : (fn == 6'h24) ? 3'd2 : (fn == 6'h25) ? 3'd3 : 3'd4;
            o = '0; o.st = 4'd2; o.aop = a;
            step(1'b0, bg, bg, z, op, fn, o, tag);
            o.st = 4'd7; o.rfwe = 1'b1; o.dst = 1'b1; o.ret = 1'b1;
            step(1'b0, bg, bg, z, op, fn, o, tag);
        end else if (op == 6'h08 || op == 6'h0D || op == 6'h0F) begin
            o = '0; o.st = 4'd3; o.srcb = 1'b1;
            o.ext = (op == 6'h08);
            o.aop = (op == 6'h08) ? 3'd0 : (op == 6'h0D) ? 3'd3 : 3'd5;
            step(1'b0, bg, bg, z, op, fn, o, tag);
            o.st = 4'd8; o.rfwe = 1'b1; o.ret = 1'b1;
            step(1'b0, bg, bg, z, op, fn, o, tag);
        end else if (op == 6'h23 || op == 6'h2B) begin
            o = '0; o.st = 4'd4; o.srcb = 1'b1; o.ext = 1'b1;
            step(1'b0, bg, bg, z, op, fn, o, tag);
            o.st = (op == 6'h23) ? 4'd5 : 4'd6; o.dreq = 1'b1; o.dwe = (op == 6'h2B);
            for (int i = 0; i < dw; i++) step(1'b0, bg, 1'b0, z, op, fn, o, tag);
            if (op == 6'h23) begin
                step(1'b0, bg, 1'b1, z, op, fn, o, tag);
                o = '0; o.st = 4'd9; o.rfwe = 1'b1; o.wsel = 1'b1; o.ret = 1'b1;
                step(1'b0, bg, bg, z, op, fn, o, tag);
            end else begin
                o.ret = 1'b1;
                step(1'b0, bg, 1'b1, z, op, fn, o, tag);
            end
        end else if (op == 6'h04) begin
            o = '0; o.st = 4'd10; o.pcs = 2'd1; o.pcwe = z; o.aop = 3'd1; o.ret = 1'b1;
            step(1'b0, bg, bg, z, op, fn, o, tag);
        end else if (op == 6'h02) begin
            o = '0; o.st = 4'd11; o.pcs = 2'd2; o.pcwe = 1'b1; o.ret = 1'b1;
            step(1'b0, bg, bg, z, op, fn, o, tag);
        end else begin
            o = '0; o.st = 4'd12; o.ill = 1'b1;
            for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, z, op, fn, o, tag);
        end
    endtask

    // LW aborted by reset while the data request is outstanding.
    task automatic lw_abort();
        ov_t o;
        o = '0; o.ireq = 1'b1; o.irwe = 1'b1; o.pcwe = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0, 6'h23, 6'h00, o, "lw_abort");
        o = '0; o.st = 4'd1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 6'h23, 6'h00, o, "lw_abort");
        o.st = 4'd4; o.srcb = 1'b1; o.ext = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 6'h23, 6'h00, o, "lw_abort");
        o.st = 4'd5; o.dreq = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 6'h23, 6'h00, o, "lw_abort");
        step(1'b0, 1'b0, 1'b0, 1'b0, 6'h23, 6'h00, o, "lw_abort");
        reset_cycle("lw_abort_rst");
    endtask

    task automatic run();
        rec_t e;
        while (plan.size() > 0) begin
            e = plan.pop_front();
            rst = e.rst;
            bus.imem_ready = e.imr;
            bus.dmem_ready = e.dmr;
            bus.alu_zero   = e.z;
            bus.opcode     = e.op;
            bus.funcode    = e.fn;
            chk.push_back(e);
            @(posedge clk); #1;
        end
    endtask

    task automatic pin(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    rec_t cr;
    ov_t  act;
    always @(negedge clk) begin
        if (chk.size() > 0) begin
            cr = chk.pop_front();
            act.st   = bus.state_dbg;
            act.ireq = bus.imem_req;
            act.irwe = bus.ir_we;
            act.pcwe = bus.pc_we;
            act.pcs  = bus.pc_src;
            act.dreq = bus.dmem_req;
            act.dwe  = bus.dmem_we;
            act.rfwe = bus.rf_we;
            act.dst  = bus.rf_dst_sel;
            act.wsel = bus.rf_wdata_sel;
            act.srcb = bus.alu_src_b;
            act.ext  = bus.ext_sel;
            act.aop  = bus.alu_op;
            act.ill  = bus.illegal;
            act.ret  = bus.retire;
            checks++;
            if (act !== cr.o || bus.retire_cnt !== cr.cnt) begin
                failures++;
                $display("FAIL %s: got state=%0d outs=%h cnt=%0d, expected state=%0d outs=%h cnt=%0d",
                         cr.tag, act.st, act, bus.retire_cnt, cr.o.st, cr.o, cr.cnt);
            end
        end
    end

    initial begin
        int n0;
        rst = 1'b1;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.alu_zero   = 1'b0;
        bus.opcode     = 6'h00;
        bus.funcode    = 6'h00;
        mcnt = '0;
        @(posedge clk); #1;

        reset_cycle("reset");
        issue(6'h00, 6'h20, 0, 0, 1'b0, 1'b1, "add");
        run();
        pin("add_retire_cnt", 32'(bus.retire_cnt), 32'd1);
        pin("add_back_in_fetch", 32'(bus.state_dbg), 32'd0);

        n0 = plan.size();
        issue(6'h23, 6'h00, 0, 3, 1'b0, 1'b0, "lw_wait3");
        pin("lw_wait3_cycles", 32'(plan.size() - n0), 32'd8);
        issue(6'h04, 6'h00, 0, 0, 1'b1, 1'b0, "beq_taken");
        issue(6'h04, 6'h00, 0, 0, 1'b0, 1'b0, "beq_not_taken");
        issue(6'h02, 6'h00, 0, 0, 1'b0, 1'b0, "jump");
        issue(6'h2B, 6'h00, 0, 0, 1'b0, 1'b0, "sw");
        run();
        pin("after_sw_retire_cnt", 32'(bus.retire_cnt), 32'd6);

        issue(6'h0D, 6'h00, 2, 0, 1'b0, 1'b1, "ori");
        issue(6'h08, 6'h00, 0, 0, 1'b0, 1'b0, "addi");
        issue(6'h0F, 6'h00, 1, 0, 1'b0, 1'b1, "lui");
        issue(6'h00, 6'h22, 0, 0, 1'b0, 1'b0, "sub");
        issue(6'h00, 6'h24, 0, 0, 1'b0, 1'b1, "and");
        issue(6'h00, 6'h25, 0, 0, 1'b0, 1'b0, "or");
        issue(6'h00, 6'h2A, 0, 0, 1'b0, 1'b0, "slt");
        issue(6'h2B, 6'h00, 0, 2, 1'b0, 1'b1, "sw_wait2");
        issue(6'h23, 6'h00, 1, 0, 1'b0, 1'b1, "lw_bg");
        issue(6'h00, 6'h21, 0, 0, 1'b0, 1'b0, "bad_funct");
        run();
        pin("bad_funct_trap_state", 32'(bus.state_dbg), 32'd12);
        pin("bad_funct_cnt_kept", 32'(bus.retire_cnt), 32'd15);

        reset_cycle("trap_rst");
        issue(6'h3F, 6'h00, 0, 0, 1'b0, 1'b1, "bad_opcode");
        run();
        pin("bad_opcode_illegal", 32'(bus.illegal), 32'd1);
        reset_cycle("trap_rst2");
        run();
        pin("trap_rst_cnt", 32'(bus.retire_cnt), 32'd0);
        pin("trap_rst_state", 32'(bus.state_dbg), 32'd0);

        issue(6'h02, 6'h00, 0, 0, 1'b0, 1'b0, "pre_abort_j");
        lw_abort();
        issue(6'h00, 6'h20, 0, 0, 1'b0, 1'b0, "add_after_abort");
        for (int i = 0; i < 16; i++) issue(6'h02, 6'h00, 0, 0, 1'b0, 1'b0, "jump_wrap");
        run();
        pin("cnt_wrap", 32'(bus.retire_cnt), 32'd1);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
